// File: rtl/bus_mem_responder.sv
// Word-addressed RAM responder for the core's BUS_* memory interface, with configurable wait states.
// Optional sticky error output is compiled in when BUS_RESP_ERR_EN is defined.
module bus_mem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] BUS_addr,
  input  logic [31:0] BUS_wdata,
  input  logic        BUS_valid,
  input  logic        BUS_mode,
  input  logic        BUS_rready,
  output logic        BUS_wready,
  output logic        BUS_rvalid,
  output logic [31:0] BUS_rdata
`ifdef BUS_RESP_ERR_EN
  ,
  output logic        bus_err
`endif
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] SPAN      = 32'(DEPTH * 4);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESP    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t         state;
  state_t         next_state;
  logic [31:0]    mem [DEPTH];
  logic [31:0]    lat_addr;
  logic [31:0]    lat_wdata;
  logic           lat_mode;
  logic [3:0]     wait_cnt;
  logic           wready;
  logic           rvalid;
  logic [31:0]    rdata;
  logic [31:0]    offset;
  logic           in_range;
  logic [AW-1:0]  index;
  logic           resp_edge;
  logic           mem_we;

  assign offset   = lat_addr - BASE_ADDR;
  assign in_range = (offset < SPAN);
  assign index    = offset[AW+1:2];

  // A read spends several cycles in RESP; only its first edge is the response edge.
  assign resp_edge = (state == ST_RESP) && (lat_mode || !rvalid);
  assign mem_we    = resp_edge && lat_mode && in_range && !rst;

  assign BUS_wready = wready;
  assign BUS_rvalid = rvalid;
  assign BUS_rdata  = rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (BUS_valid) begin
          next_state = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd1) begin
          next_state = ST_RESP;
        end else begin
          next_state = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (lat_mode) begin
          next_state = ST_RELEASE;
        end else if (rvalid && BUS_rready) begin
          next_state = ST_RELEASE;
        end else begin
          next_state = ST_RESP;
        end
      end
      // Holding here until valid drops keeps a still-asserted request from being served twice.
      ST_RELEASE: begin
        if (!BUS_valid) begin
          next_state = ST_IDLE;
        end else begin
          next_state = ST_RELEASE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_addr  <= 32'h0000_0000;
      lat_wdata <= 32'h0000_0000;
      lat_mode  <= 1'b0;
      wait_cnt  <= 4'd0;
      wready    <= 1'b0;
      rvalid    <= 1'b0;
      rdata     <= 32'h0000_0000;
    end else begin
      wready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (BUS_valid) begin
            lat_addr  <= BUS_addr;
            lat_wdata <= BUS_wdata;
            lat_mode  <= BUS_mode;
            wait_cnt  <= WAIT_LOAD;
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
        end
        ST_RESP: begin
          if (lat_mode) begin
            wready <= 1'b1;
          end else if (!rvalid) begin
            rvalid <= 1'b1;
            rdata  <= in_range ? mem[index] : 32'h0000_0000;
          end else if (BUS_rready) begin
            rvalid <= 1'b0;
            rdata  <= 32'h0000_0000;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Storage is deliberately left unreset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[index] <= lat_wdata;
    end
  end

`ifdef BUS_RESP_ERR_EN
  logic err;
  assign bus_err = err;

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (resp_edge && (!in_range || (lat_addr[1:0] != 2'b00))) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bus_mem_responder.sv
// Self-checking bench for bus_mem_responder: one instance with no wait states, one with three.
// Read expectations flow through a scoreboard queue; build with BUS_RESP_ERR_EN to also check bus_err.
module tb_bus_mem_responder;

  logic        clk;
  logic [1:0]  rst_i;
  logic [1:0]  valid_i;
  logic [1:0]  mode_i;
  logic [1:0]  rready_i;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  wready_o;
  logic [1:0]  rvalid_o;
  logic [31:0] rdata0, rdata1;
`ifdef BUS_RESP_ERR_EN
  logic [1:0]  err_o;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] sb [$];

  bus_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst_i[0]), .BUS_addr(addr0), .BUS_wdata(wdata0),
    .BUS_valid(valid_i[0]), .BUS_mode(mode_i[0]), .BUS_rready(rready_i[0]),
    .BUS_wready(wready_o[0]), .BUS_rvalid(rvalid_o[0]), .BUS_rdata(rdata0)
`ifdef BUS_RESP_ERR_EN
    , .bus_err(err_o[0])
`endif
  );

  bus_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst_i[1]), .BUS_addr(addr1), .BUS_wdata(wdata1),
    .BUS_valid(valid_i[1]), .BUS_mode(mode_i[1]), .BUS_rready(rready_i[1]),
    .BUS_wready(wready_o[1]), .BUS_rvalid(rvalid_o[1]), .BUS_rdata(rdata1)
`ifdef BUS_RESP_ERR_EN
    , .bus_err(err_o[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] rdata_of(input int d);
    return (d == 0) ? rdata0 : rdata1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int d, input logic [31:0] a, input logic [31:0] v);
    if (d == 0) begin
      addr0 = a;
      wdata0 = v;
    end else begin
      addr1 = a;
      wdata1 = v;
    end
  endtask

  task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] v, input int hold);
    int wc;
    wc = (d == 0) ? 0 : 3;
    @(negedge clk);
    set_req(d, a, v);
    mode_i[d]  = 1'b1;
    valid_i[d] = 1'b1;
    @(posedge clk);
    #2;
    set_req(d, 32'hFFFF_FFF0, ~v);
    for (int i = 1; i <= wc + 1; i++) begin
      @(posedge clk);
      #1;
      check("wr_wready", {31'd0, wready_o[d]}, {31'd0, (i == wc + 1)});
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("wr_hold_wready", {31'd0, wready_o[d]}, 32'd0);
    end
    @(negedge clk);
    valid_i[d] = 1'b0;
    mode_i[d]  = 1'b0;
    @(posedge clk);
    #1;
    check("wr_after_wready", {31'd0, wready_o[d]}, 32'd0);
  endtask

  task automatic do_read(input int d, input logic [31:0] a, input logic [31:0] exp, input int delay);
    int wc;
    logic [31:0] e;
    wc = (d == 0) ? 0 : 3;
    sb.push_back(exp);
    @(negedge clk);
    set_req(d, a, 32'h0000_0000);
    mode_i[d]   = 1'b0;
    valid_i[d]  = 1'b1;
    rready_i[d] = (delay == 0);
    @(posedge clk);
    #2;
    set_req(d, 32'hFFFF_FFF0, 32'h0000_0000);
    mode_i[d] = 1'b1;
    for (int i = 1; i <= wc + 1; i++) begin
      @(posedge clk);
      #1;
      check("rd_rvalid", {31'd0, rvalid_o[d]}, {31'd0, (i == wc + 1)});
      if (i < wc + 1) check("rd_rdata_idle", rdata_of(d), 32'h0000_0000);
    end
    if (sb.size() == 0) begin
      check("rd_scoreboard_empty", 32'd0, 32'd1);
      e = 32'h0000_0000;
    end else begin
      e = sb.pop_front();
    end
    check("rd_rdata", rdata_of(d), e);
    for (int i = 0; i < delay; i++) begin
      @(posedge clk);
      #1;
      check("rd_hold_rvalid", {31'd0, rvalid_o[d]}, 32'd1);
      check("rd_hold_rdata", rdata_of(d), e);
    end
    if (delay > 0) begin
      @(negedge clk);
      rready_i[d] = 1'b1;
    end
    @(posedge clk);
    #1;
    check("rd_done_rvalid", {31'd0, rvalid_o[d]}, 32'd0);
    check("rd_done_rdata", rdata_of(d), 32'h0000_0000);
    @(negedge clk);
    valid_i[d]  = 1'b0;
    rready_i[d] = 1'b0;
    mode_i[d]   = 1'b0;
    @(posedge clk);
  endtask

  task automatic check_idle_outputs(input int d, input string tag);
    check({tag, "_wready"}, {31'd0, wready_o[d]}, 32'd0);
    check({tag, "_rvalid"}, {31'd0, rvalid_o[d]}, 32'd0);
    check({tag, "_rdata"}, rdata_of(d), 32'h0000_0000);
  endtask

  initial begin
    rst_i    = 2'b11;
    valid_i  = 2'b00;
    mode_i   = 2'b00;
    rready_i = 2'b00;
    addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs(0, "reset0");
    check_idle_outputs(1, "reset3");
`ifdef BUS_RESP_ERR_EN
    check("reset_err0", {31'd0, err_o[0]}, 32'd0);
    check("reset_err3", {31'd0, err_o[1]}, 32'd0);
`endif
    @(negedge clk);
    rst_i = 2'b00;

    // Zero wait states: held-valid write, read with rready already high.
    do_write(0, 32'h0000_0010, 32'hA5A5_0001, 4);
    do_read(0, 32'h0000_0010, 32'hA5A5_0001, 0);
`ifdef BUS_RESP_ERR_EN
    check("err_after_good", {31'd0, err_o[0]}, 32'd0);
`endif
    do_read(0, 32'h0000_1000, 32'h0000_0000, 1);
`ifdef BUS_RESP_ERR_EN
    check("err_out_of_range", {31'd0, err_o[0]}, 32'd1);
`endif
    do_write(0, 32'h0000_0013, 32'h0000_0077, 0);
    do_read(0, 32'h0000_0010, 32'h0000_0077, 0);
    do_write(0, 32'h0000_0FFC, 32'hCAFE_BABE, 0);
    do_read(0, 32'h0000_0FFC, 32'hCAFE_BABE, 2);
`ifdef BUS_RESP_ERR_EN
    check("err_sticky", {31'd0, err_o[0]}, 32'd1);
`endif
    @(negedge clk);
    rst_i[0] = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs(0, "rst0_again");
`ifdef BUS_RESP_ERR_EN
    check("err_cleared", {31'd0, err_o[0]}, 32'd0);
`endif
    @(negedge clk);
    rst_i[0] = 1'b0;
    do_read(0, 32'h0000_0010, 32'h0000_0077, 0);

    // Three wait states: stalled read, then reset during a pending write.
    do_write(1, 32'h0000_0004, 32'h1234_5678, 0);
    do_read(1, 32'h0000_0004, 32'h1234_5678, 5);
    do_write(1, 32'h0000_0020, 32'h0000_0011, 0);
    @(negedge clk);
    set_req(1, 32'h0000_0020, 32'hDEAD_BEEF);
    mode_i[1]  = 1'b1;
    valid_i[1] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_i[1] = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs(1, "rst_mid_write");
    @(negedge clk);
    rst_i[1]   = 1'b0;
    valid_i[1] = 1'b0;
    mode_i[1]  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("rst_no_wready", {31'd0, wready_o[1]}, 32'd0);
    end
    do_read(1, 32'h0000_0020, 32'h0000_0011, 0);
    do_read(1, 32'h0000_0004, 32'h1234_5678, 1);
`ifdef BUS_RESP_ERR_EN
    check("err3_clean", {31'd0, err_o[1]}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
